// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StCalc = 2'd1;
    localparam state_t StFix  = 2'd2;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result handshake bundle between the arithmetic unit and the multiplier.
interface seq_mult_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the multiplier: IDLE/CALC/FIX walk, step counter and busy/done.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mplier_next_zero,
    output logic load,
    output logic step,
    output logic fix,
    output logic busy,
    output logic done
);

    localparam int unsigned CntW = clog2(WIDTH);

    state_t            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              done_q;
    logic              last_step;

    assign load = (state_q == StIdle) && start;
    assign step = (state_q == StCalc);
    assign fix  = (state_q == StFix);
    assign busy = (state_q != StIdle);
    assign done = done_q;

    // Early-out looks at the multiplier after this step's shift.
    assign last_step = (count_q == CntW'(WIDTH - 1)) || (EARLY_OUT && mplier_next_zero);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCalc;
                    count_d = '0;
                end
            end
            StCalc: begin
                count_d = count_q + CntW'(1);
                if (last_step) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= fix;
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier with optional signed mode and early-out.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input logic       clk,
    input logic       rst,
    seq_mult_if.slave bus
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic             neg_q;
    logic [PW-1:0]    product_q;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic             neg_in;
    logic             load, step, fix;
    logic             busy, done;
    logic             mplier_next_zero;

    // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
    assign abs_a  = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b  = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign neg_in = bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

    assign mplier_next_zero = (mplier_q[WIDTH-1:1] == '0);

    seq_mult_ctrl #(
        .WIDTH     (WIDTH),
        .EARLY_OUT (EARLY_OUT)
    ) u_ctrl (
        .clk              (clk),
        .rst              (rst),
        .start            (bus.start),
        .mplier_next_zero (mplier_next_zero),
        .load             (load),
        .step             (step),
        .fix              (fix),
        .busy             (busy),
        .done             (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            if (load) begin
                mcand_q  <= {{WIDTH{1'b0}}, abs_a};
                mplier_q <= abs_b;
                neg_q    <= neg_in;
                acc_q    <= '0;
            end else if (step) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= {mcand_q[PW-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            end
            if (fix) begin
                product_q <= neg_q ? -acc_q : acc_q;
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;

endmodule
